// File: rtl/smem_pkg.sv
// Shared parameters, types and issue-FSM encoding for the occurrence line responder slice.
package smem_pkg;
   localparam int unsigned CL             = 512;
   localparam int unsigned ADDR_W         = 42;
   localparam int unsigned READ_NUM_WIDTH = 8;
   localparam int unsigned DEPTH          = 8;
   localparam int unsigned SLOT_W         = 3;

   typedef logic [SLOT_W-1:0]         slot_t;
   typedef logic [SLOT_W:0]           ptr_t;
   typedef logic [SLOT_W:0]           tag_t;
   typedef logic [CL-1:0]             line_t;
   typedef logic [ADDR_W-1:0]         addr_t;
   typedef logic [READ_NUM_WIDTH-1:0] rnum_t;

   typedef enum logic [1:0] {
      ISS_IDLE,
      ISS_K,
      ISS_L
   } iss_state_t;

   localparam ptr_t FULL_COUNT = ptr_t'(DEPTH);
endpackage

// File: rtl/occ_slot_buffer.sv
// Per-slot storage of the k and l cache lines; per-half write, one read port.
module occ_slot_buffer
   import smem_pkg::*;
(
   input  logic  clk,
   input  logic  wr_en,
   input  slot_t wr_slot,
   input  logic  wr_half,
   input  logic  wr_both,
   input  line_t wr_data,
   input  slot_t rd_slot,
   output line_t rd_line_k,
   output line_t rd_line_l
);
   line_t mem_k [DEPTH];
   line_t mem_l [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en && (!wr_half || wr_both)) mem_k[wr_slot] <= wr_data;
      if (wr_en && (wr_half || wr_both))  mem_l[wr_slot] <= wr_data;
   end

   assign rd_line_k = mem_k[rd_slot];
   assign rd_line_l = mem_l[rd_slot];
endmodule

// File: rtl/occ_line_responder.sv
// Accepts k/l occurrence requests, issues one or two tagged line reads, reorders returns
// and delivers paired lines with read_num in request order.
module occ_line_responder
   import smem_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_W-1:0]         req_addr_k,
   input  logic [ADDR_W-1:0]         req_addr_l,
   input  logic [READ_NUM_WIDTH-1:0] req_read_num,
   output logic                      mem_rd_valid,
   input  logic                      mem_rd_ready,
   output logic [ADDR_W-1:0]         mem_rd_addr,
   output logic [SLOT_W:0]           mem_rd_tag,
   input  logic                      mem_rsp_valid,
   input  logic [SLOT_W:0]           mem_rsp_tag,
   input  logic [CL-1:0]             mem_rsp_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [READ_NUM_WIDTH-1:0] rsp_read_num,
   output logic [CL-1:0]             rsp_line_k,
   output logic [CL-1:0]             rsp_line_l,
   output logic                      err_tag
);
   addr_t slot_k  [DEPTH];
   addr_t slot_l  [DEPTH];
   rnum_t slot_rn [DEPTH];

   logic [DEPTH-1:0] sh, iss_k, iss_l, vk, vl;
   ptr_t       wr_ptr, iss_ptr, rd_ptr, count;
   iss_state_t state;

   logic  accept, retire, rsp_half, rsp_ok, rsp_wr, rsp_both, more, head_done;
   slot_t wr_slot, iss_slot, nxt_slot, rd_slot, rsp_slot;
   ptr_t  iss_next;
   line_t buf_k, buf_l;

   always_comb begin
      req_ready = (count != FULL_COUNT);
      accept    = req_valid & req_ready;
      retire    = rsp_valid & rsp_ready;
      wr_slot   = wr_ptr[SLOT_W-1:0];
      iss_slot  = iss_ptr[SLOT_W-1:0];
      iss_next  = iss_ptr + 1'b1;
      nxt_slot  = iss_next[SLOT_W-1:0];
      more      = (iss_next != wr_ptr);
      rd_slot   = rd_ptr[SLOT_W-1:0];
      rsp_slot  = mem_rsp_tag[SLOT_W:1];
      rsp_half  = mem_rsp_tag[0];
      // A return is only legal for a half that was issued and has not landed yet.
      rsp_ok    = rsp_half ? (iss_l[rsp_slot] & ~vl[rsp_slot]) : (iss_k[rsp_slot] & ~vk[rsp_slot]);
      rsp_wr    = mem_rsp_valid & rsp_ok;
      rsp_both  = sh[rsp_slot] & ~rsp_half;
      head_done = (rd_ptr != wr_ptr) & vk[rd_slot] & vl[rd_slot];
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         slot_k[wr_slot]  <= req_addr_k;
         slot_l[wr_slot]  <= req_addr_l;
         slot_rn[wr_slot] <= req_read_num;
      end
   end

   occ_slot_buffer u_buf (
      .clk       (clk),
      .wr_en     (rsp_wr),
      .wr_slot   (rsp_slot),
      .wr_half   (rsp_half),
      .wr_both   (rsp_both),
      .wr_data   (mem_rsp_data),
      .rd_slot   (rd_slot),
      .rd_line_k (buf_k),
      .rd_line_l (buf_l)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         iss_ptr      <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         sh           <= '0;
         iss_k        <= '0;
         iss_l        <= '0;
         vk           <= '0;
         vl           <= '0;
         state        <= ISS_IDLE;
         mem_rd_valid <= 1'b0;
         mem_rd_addr  <= '0;
         mem_rd_tag   <= '0;
         rsp_valid    <= 1'b0;
         rsp_read_num <= '0;
         rsp_line_k   <= '0;
         rsp_line_l   <= '0;
         err_tag      <= 1'b0;
      end else begin
         case ({accept, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         // Retired and newly touched slots never coincide, so bit-level updates cannot collide.
         if (retire) begin
            rsp_valid      <= 1'b0;
            rd_ptr         <= rd_ptr + 1'b1;
            vk[rd_slot]    <= 1'b0;
            vl[rd_slot]    <= 1'b0;
            sh[rd_slot]    <= 1'b0;
            iss_k[rd_slot] <= 1'b0;
            iss_l[rd_slot] <= 1'b0;
         end else if (!rsp_valid && head_done) begin
            rsp_valid    <= 1'b1;
            rsp_read_num <= slot_rn[rd_slot];
            rsp_line_k   <= buf_k;
            rsp_line_l   <= buf_l;
         end

         if (accept) begin
            wr_ptr      <= wr_ptr + 1'b1;
            sh[wr_slot] <= (req_addr_k == req_addr_l);
         end

         if (mem_rsp_valid) begin
            if (rsp_ok) begin
               if (!rsp_half || rsp_both) vk[rsp_slot] <= 1'b1;
               if (rsp_half || rsp_both)  vl[rsp_slot] <= 1'b1;
            end else begin
               err_tag <= 1'b1;
            end
         end

         case (state)
            ISS_IDLE: begin
               if (iss_ptr != wr_ptr) begin
                  state        <= ISS_K;
                  mem_rd_valid <= 1'b1;
                  mem_rd_addr  <= slot_k[iss_slot];
                  mem_rd_tag   <= {iss_slot, 1'b0};
               end
            end
            ISS_K: begin
               if (mem_rd_ready) begin
                  iss_k[iss_slot] <= 1'b1;
                  if (sh[iss_slot]) begin
                     iss_ptr <= iss_next;
                     if (more) begin
                        mem_rd_addr <= slot_k[nxt_slot];
                        mem_rd_tag  <= {nxt_slot, 1'b0};
                     end else begin
                        state        <= ISS_IDLE;
                        mem_rd_valid <= 1'b0;
                     end
                  end else begin
                     state       <= ISS_L;
                     mem_rd_addr <= slot_l[iss_slot];
                     mem_rd_tag  <= {iss_slot, 1'b1};
                  end
               end
            end
            ISS_L: begin
               if (mem_rd_ready) begin
                  iss_l[iss_slot] <= 1'b1;
                  iss_ptr         <= iss_next;
                  if (more) begin
                     state       <= ISS_K;
                     mem_rd_addr <= slot_k[nxt_slot];
                     mem_rd_tag  <= {nxt_slot, 1'b0};
                  end else begin
                     state        <= ISS_IDLE;
                     mem_rd_valid <= 1'b0;
                  end
               end
            end
            default: state <= ISS_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_occ_line_responder.sv
// Bench for occ_line_responder: scoreboard of requests/reads/returns plus directed scenarios.
module tb_occ_line_responder;
   import smem_pkg::*;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  req_valid = 1'b0, req_ready;
   addr_t req_addr_k = '0, req_addr_l = '0;
   rnum_t req_read_num = '0;
   logic  mem_rd_valid, mem_rd_ready = 1'b0;
   addr_t mem_rd_addr;
   tag_t  mem_rd_tag;
   logic  mem_rsp_valid = 1'b0;
   tag_t  mem_rsp_tag = '0;
   line_t mem_rsp_data = '0;
   logic  rsp_valid, rsp_ready = 1'b0;
   rnum_t rsp_read_num;
   line_t rsp_line_k, rsp_line_l;
   logic  err_tag;

   always #5 clk = ~clk;

   occ_line_responder dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr_k(req_addr_k), .req_addr_l(req_addr_l), .req_read_num(req_read_num),
      .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
      .mem_rd_addr(mem_rd_addr), .mem_rd_tag(mem_rd_tag),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_read_num(rsp_read_num),
      .rsp_line_k(rsp_line_k), .rsp_line_l(rsp_line_l), .err_tag(err_tag)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: requests by allocation order, expected reads, returned data per slot.
   typedef struct packed {addr_t addr; tag_t tag;} rd_t;
   addr_t m_k [DEPTH];
   addr_t m_l [DEPTH];
   rnum_t m_rn [DEPTH];
   logic  m_sh [DEPTH];
   logic [1:0] m_iss [DEPTH];
   logic [1:0] m_got [DEPTH];
   line_t m_dk [DEPTH];
   line_t m_dl [DEPTH];
   int    m_wr, m_rd, n_acc, n_ret, rsp_stall, rd_stall;
   logic  m_err;
   rd_t   exp_rd [$];
   tag_t  inflight [$];
   rnum_t ret_rn [$];

   function automatic line_t rand_line();
      line_t v;
      for (int unsigned i = 0; i < CL / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic addr_t rand_addr();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[ADDR_W-1:0];
   endfunction

   task automatic model_clear();
      for (int unsigned i = 0; i < DEPTH; i++) begin
         m_iss[i] = '0; m_got[i] = '0; m_sh[i] = 1'b0;
      end
      m_wr = 0; m_rd = 0; n_acc = 0; n_ret = 0; rsp_stall = 0; rd_stall = 0; m_err = 1'b0;
      exp_rd.delete(); inflight.delete(); ret_rn.delete();
   endtask

   // Compare current outputs against the scoreboard, account for the coming edge, advance.
   task automatic tick();
      slot_t hs, s;
      logic  h, head_done, ready_m;
      rd_t   r;
      ready_m = ((m_wr - m_rd) != DEPTH);
      chk("req_ready", req_ready, ready_m);
      chk("err_tag", err_tag, m_err);
      if (mem_rd_valid) begin
         chk("mem_rd_expected", exp_rd.size() != 0, 1);
         if (exp_rd.size() != 0) begin
            chk("mem_rd_addr", mem_rd_addr, exp_rd[0].addr);
            chk("mem_rd_tag", mem_rd_tag, exp_rd[0].tag);
         end
         rd_stall = 0;
      end else if (exp_rd.size() != 0) begin
         rd_stall++;
         if (rd_stall > 3) begin chk("mem_rd_liveness", mem_rd_valid, 1); rd_stall = 0; end
      end
      hs = m_rd[SLOT_W-1:0];
      head_done = (m_wr != m_rd) && (m_got[hs] == 2'b11);
      if (rsp_valid) begin
         chk("rsp_head_complete", head_done, 1);
         if (m_wr != m_rd) begin
            chk("rsp_read_num", rsp_read_num, m_rn[hs]);
            chk("rsp_line_k", rsp_line_k, m_dk[hs]);
            chk("rsp_line_l", rsp_line_l, m_dl[hs]);
         end
         rsp_stall = 0;
      end else if (head_done) begin
         rsp_stall++;
         if (rsp_stall > 3) begin chk("rsp_liveness", rsp_valid, 1); rsp_stall = 0; end
      end

      if (rsp_valid && rsp_ready && m_wr != m_rd) begin
         ret_rn.push_back(m_rn[hs]);
         n_ret++;
         m_got[hs] = '0; m_iss[hs] = '0; m_sh[hs] = 1'b0;
         m_rd++;
      end
      if (mem_rd_valid && mem_rd_ready && exp_rd.size() != 0) begin
         r = exp_rd.pop_front();
         m_iss[r.tag[SLOT_W:1]][r.tag[0]] = 1'b1;
         inflight.push_back(r.tag);
      end
      if (mem_rsp_valid) begin
         s = mem_rsp_tag[SLOT_W:1];
         h = mem_rsp_tag[0];
         if (m_iss[s][h] && !m_got[s][h]) begin
            if (!h && m_sh[s]) begin
               m_got[s] = 2'b11; m_dk[s] = mem_rsp_data; m_dl[s] = mem_rsp_data;
            end else begin
               m_got[s][h] = 1'b1;
               if (h) m_dl[s] = mem_rsp_data; else m_dk[s] = mem_rsp_data;
            end
         end else begin
            m_err = 1'b1;
         end
      end
      if (req_valid && ready_m) begin
         s = m_wr[SLOT_W-1:0];
         m_k[s] = req_addr_k; m_l[s] = req_addr_l; m_rn[s] = req_read_num;
         m_sh[s] = (req_addr_k == req_addr_l);
         exp_rd.push_back('{addr: req_addr_k, tag: {s, 1'b0}});
         if (!m_sh[s]) exp_rd.push_back('{addr: req_addr_l, tag: {s, 1'b1}});
         m_wr++;
         n_acc++;
      end
      @(posedge clk);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
   endtask

   task automatic present(input tag_t t, input line_t d);
      mem_rsp_valid = 1'b1; mem_rsp_tag = t; mem_rsp_data = d;
   endtask

   task automatic serve_one();
      if (inflight.size() != 0) present(inflight.pop_front(), rand_line());
   endtask

   task automatic wait_rd();
      for (int i = 0; i < 20 && !mem_rd_valid; i++) tick();
      chk("wait_mem_rd", mem_rd_valid, 1);
   endtask

   task automatic wait_rsp();
      for (int i = 0; i < 40 && !rsp_valid; i++) tick();
      chk("wait_rsp", rsp_valid, 1);
   endtask

   task automatic wait_issued();
      for (int i = 0; i < 40 && exp_rd.size() != 0; i++) tick();
      chk("issue_drain", exp_rd.size() == 0, 1);
   endtask

   task automatic check_reset_outputs(input string p);
      chk({p, "_req_ready"}, req_ready, 1);
      chk({p, "_mem_rd_valid"}, mem_rd_valid, 0);
      chk({p, "_mem_rd_addr"}, mem_rd_addr, 0);
      chk({p, "_mem_rd_tag"}, mem_rd_tag, 0);
      chk({p, "_rsp_valid"}, rsp_valid, 0);
      chk({p, "_rsp_read_num"}, rsp_read_num, 0);
      chk({p, "_rsp_line_k"}, rsp_line_k, 0);
      chk({p, "_rsp_line_l"}, rsp_line_l, 0);
      chk({p, "_err_tag"}, err_tag, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 1'b0; mem_rd_ready = 1'b0; mem_rsp_valid = 1'b0; rsp_ready = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
   endtask

   initial begin
      line_t d0, d1;
      tag_t  t3_order [6];
      int    a0;

      // 1: basic k/l pair, in-order returns
      do_reset();
      rsp_ready = 1'b1; mem_rd_ready = 1'b1;
      req_valid = 1'b1; req_addr_k = 42'h100; req_addr_l = 42'h104; req_read_num = 8'd5;
      tick();
      req_valid = 1'b0;
      wait_rd();
      chk("t1_rd0_addr", mem_rd_addr, 42'h100);
      chk("t1_rd0_tag", mem_rd_tag, 4'd0);
      tick();
      chk("t1_rd1_valid", mem_rd_valid, 1);
      chk("t1_rd1_addr", mem_rd_addr, 42'h104);
      chk("t1_rd1_tag", mem_rd_tag, 4'd1);
      tick();
      chk("t1_rd_done", mem_rd_valid, 0);
      tick(); tick();
      d0 = rand_line(); d1 = rand_line();
      present(4'd0, d0); tick();
      present(4'd1, d1); tick();
      chk("t1_rsp_not_yet", rsp_valid, 0);
      tick();
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_read_num", rsp_read_num, 8'd5);
      chk("t1_line_k", rsp_line_k, d0);
      chk("t1_line_l", rsp_line_l, d1);
      tick();
      chk("t1_retired", rsp_valid, 0);

      // 2: shared line, single read
      do_reset();
      rsp_ready = 1'b1; mem_rd_ready = 1'b1;
      req_valid = 1'b1; req_addr_k = 42'h2A0; req_addr_l = 42'h2A0; req_read_num = 8'd7;
      tick();
      req_valid = 1'b0;
      wait_rd();
      chk("t2_addr", mem_rd_addr, 42'h2A0);
      chk("t2_tag", mem_rd_tag, 4'd0);
      tick();
      for (int i = 0; i < 4; i++) begin chk("t2_single_read", mem_rd_valid, 0); tick(); end
      d0 = rand_line();
      present(4'd0, d0); tick();
      wait_rsp();
      chk("t2_line_k", rsp_line_k, d0);
      chk("t2_line_l", rsp_line_l, d0);
      chk("t2_read_num", rsp_read_num, 8'd7);
      tick();

      // 3: out-of-order returns across three slots
      do_reset();
      rsp_ready = 1'b1; mem_rd_ready = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_addr_k = 42'h1000 + 42'(i * 16);
         req_addr_l = req_addr_k + 42'h8;
         req_read_num = 8'(10 + i);
         tick();
      end
      req_valid = 1'b0;
      wait_issued();
      inflight.delete();
      t3_order = '{4'd5, 4'd1, 4'd2, 4'd4, 4'd0, 4'd3};
      for (int i = 0; i < 6; i++) begin
         present(t3_order[i], rand_line());
         tick();
         if (i < 4) chk("t3_hold", rsp_valid, 0);
      end
      for (int i = 0; i < 20 && n_ret < 3; i++) tick();
      chk("t3_count", n_ret, 3);
      if (ret_rn.size() == 3) begin
         chk("t3_order0", ret_rn[0], 8'd10);
         chk("t3_order1", ret_rn[1], 8'd11);
         chk("t3_order2", ret_rn[2], 8'd12);
      end

      // 4: fill the ring with the consumer stalled
      do_reset();
      mem_rd_ready = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
         req_valid = 1'b1; req_addr_k = rand_addr(); req_addr_l = rand_addr(); req_read_num = 8'(i);
         tick();
      end
      chk("t4_accepts", n_acc, 8);
      chk("t4_full", req_ready, 0);
      req_read_num = 8'd99;
      for (int i = 0; i < 200 && !rsp_valid; i++) begin serve_one(); tick(); end
      chk("t4_rsp", rsp_valid, 1);
      chk("t4_still_full", req_ready, 0);
      a0 = n_acc;
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin serve_one(); tick(); end
      chk("t4_one_more", n_acc - a0, 1);
      req_valid = 1'b0;

      // 5: bad and duplicate return tags
      do_reset();
      present(4'd6, rand_line());
      tick();
      chk("t5_err_set", err_tag, 1);
      rsp_ready = 1'b1; mem_rd_ready = 1'b1;
      req_valid = 1'b1; req_addr_k = 42'h300; req_addr_l = 42'h340; req_read_num = 8'h55;
      tick();
      req_valid = 1'b0;
      wait_issued();
      inflight.delete();
      d0 = rand_line(); d1 = rand_line();
      present(4'd0, d0); tick();
      present(4'd0, rand_line()); tick();
      chk("t5_err_sticky", err_tag, 1);
      present(4'd1, d1); tick();
      wait_rsp();
      chk("t5_line_k", rsp_line_k, d0);
      chk("t5_line_l", rsp_line_l, d1);
      chk("t5_read_num", rsp_read_num, 8'h55);
      tick();

      // 6: asynchronous reset with slots outstanding
      do_reset();
      mem_rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_addr_k = rand_addr(); req_addr_l = rand_addr(); req_read_num = 8'(i);
         tick();
      end
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin serve_one(); tick(); end
      #2 rst = 1'b1;
      #1 check_reset_outputs("t6");
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      mem_rd_ready = 1'b1;
      req_valid = 1'b1; req_addr_k = 42'h500; req_addr_l = 42'h540; req_read_num = 8'd1;
      tick();
      req_valid = 1'b0;
      wait_rd();
      chk("t6_tag_reuse", mem_rd_tag, 4'd0);
      chk("t6_addr", mem_rd_addr, 42'h500);

      // Randomized traffic against the scoreboard
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         req_valid    = ($urandom_range(0, 2) != 0);
         req_addr_k   = rand_addr();
         req_addr_l   = ($urandom_range(0, 3) == 0) ? req_addr_k : rand_addr();
         req_read_num = rnum_t'($urandom());
         mem_rd_ready = ($urandom_range(0, 3) != 0);
         rsp_ready    = ($urandom_range(0, 2) != 0);
         if (inflight.size() != 0 && $urandom_range(0, 2) != 0) begin
            int unsigned idx;
            idx = $urandom_range(0, inflight.size() - 1);
            present(inflight[idx], rand_line());
            inflight.delete(idx);
         end
         tick();
      end
      req_valid = 1'b0; mem_rd_ready = 1'b1; rsp_ready = 1'b1;
      for (int i = 0; i < 400 && m_wr != m_rd; i++) begin serve_one(); tick(); end
      chk("drain_empty", m_wr == m_rd, 1);
      chk("drain_no_err", err_tag, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
